// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the dual-clock FIFO: synchronized write pointer, memory read port,
// consumer handshake and the status outputs of the read controller.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH:0]   rq2_wptr;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  R_READY;
  logic [ADDR_WIDTH:0]   R_ptr;
  logic [ADDR_WIDTH-1:0] R_addr;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic                  R_VALID;
  logic                  EMPTY;
  logic                  ALMOST_EMPTY;
  logic [ADDR_WIDTH:0]   R_LEVEL;
  logic                  SYNC_ERR;

  modport master (
    input  rq2_wptr, RD_DATA, R_READY,
    output R_ptr, R_addr, R_DATA, R_VALID, EMPTY, ALMOST_EMPTY, R_LEVEL, SYNC_ERR
  );

  modport slave (
    output rq2_wptr, RD_DATA, R_READY,
    input  R_ptr, R_addr, R_DATA, R_VALID, EMPTY, ALMOST_EMPTY, R_LEVEL, SYNC_ERR
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: binary/gray read pointers, empty detection,
// one-entry first-word-fall-through output register, occupancy and pointer-consistency error.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AE_THRESH  = 1
) (
  input logic           R_CLK,
  input logic           R_RST,
  fifo_rd_ctrl_if.master bus
);
  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1 << ADDR_WIDTH);
  localparam logic [PW-1:0] AE_LIM = PW'(AE_THRESH);

  typedef enum logic {EMPTY_OUT, FULL_OUT} hs_state_e;

  hs_state_e             state_q, state_d;
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  ae_q, ae_d;
  logic                  sync_err_q, sync_err_d;

  logic                  empty;
  logic                  pop;
  logic [PW-1:0]         wbin_s;
  logic [PW-1:0]         diff_now;
  logic [PW-1:0]         diff_next;

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      state_q    <= EMPTY_OUT;
      rbin_q     <= '0;
      rptr_q     <= '0;
      rdata_q    <= '0;
      level_q    <= '0;
      ae_q       <= 1'b1;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rdata_q    <= rdata_d;
      level_q    <= level_d;
      ae_q       <= ae_d;
      sync_err_q <= sync_err_d;
    end
  end

  always_comb begin
    empty = (rptr_q == bus.rq2_wptr);
    pop   = !empty && ((state_q == EMPTY_OUT) || bus.R_READY);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY_OUT: if (pop) state_d = FULL_OUT;
      FULL_OUT:  if (bus.R_READY && !pop) state_d = EMPTY_OUT;
      default:   state_d = EMPTY_OUT;
    endcase
  end

  // Gray-to-binary as the XOR of all right shifts of the synchronized write pointer.
  always_comb begin
    wbin_s = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      wbin_s = wbin_s ^ (bus.rq2_wptr >> i);
    end
  end

  // R_ptr is loaded with the gray code of the next rbin, so it never lags the binary pointer.
  // The error check uses the pre-edge pointer; the level reflects the post-pop pointer.
  always_comb begin
    rbin_d     = pop ? rbin_q + 1'b1 : rbin_q;
    rptr_d     = rbin_d ^ (rbin_d >> 1);
    rdata_d    = pop ? bus.RD_DATA : rdata_q;
    diff_now   = wbin_s - rbin_q;
    diff_next  = wbin_s - rbin_d;
    level_d    = diff_next;
    ae_d       = (diff_next <= AE_LIM);
    sync_err_d = sync_err_q | (diff_now > DEPTH);
  end

  always_comb begin
    bus.R_VALID      = (state_q == FULL_OUT);
    bus.R_DATA       = rdata_q;
    bus.R_ptr        = rptr_q;
    bus.R_addr       = rbin_q[ADDR_WIDTH-1:0];
    bus.EMPTY        = empty;
    bus.R_LEVEL      = level_q;
    bus.ALMOST_EMPTY = ae_q;
    bus.SYNC_ERR     = sync_err_q;
  end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus random traffic against a word-count model
// of the read side (writer count, reader count, output slot).
module tb_fifo_rd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) bus ();

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .AE_THRESH(1)) dut (
    .R_CLK(clk),
    .R_RST(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [8];
  assign bus.RD_DATA = mem[bus.R_addr];

  int total = 0;
  int bad   = 0;

  // Reference state: words written (w), words popped (rd), output slot contents.
  int         w  = 0;
  int         rd = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  logic [3:0] m_level = '0;
  bit         m_ae    = 1'b1;
  bit         m_err   = 1'b0;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs, check state, advance the model across the next rising edge.
  task automatic step(input bit rst_i, input bit rdy_i);
    int avail;
    bit pop;
    rst = rst_i;
    bus.R_READY  = rdy_i;
    bus.rq2_wptr = gray(4'(w));
    #1;
    avail = (w - rd) & 15;
    chk("empty",   32'(bus.EMPTY),        32'(avail == 0));
    chk("valid",   32'(bus.R_VALID),      32'(m_valid));
    chk("data",    32'(bus.R_DATA),       32'(m_data));
    chk("ptr",     32'(bus.R_ptr),        32'(gray(4'(rd))));
    chk("addr",    32'(bus.R_addr),       32'(rd & 7));
    chk("level",   32'(bus.R_LEVEL),      32'(m_level));
    chk("aempty",  32'(bus.ALMOST_EMPTY), 32'(m_ae));
    chk("syncerr", 32'(bus.SYNC_ERR),     32'(m_err));
    if (rst_i) begin
      rd = 0; m_valid = 0; m_data = '0; m_level = '0; m_ae = 1; m_err = 0;
    end else begin
      pop = (avail != 0) && (!m_valid || rdy_i);
      if (avail > 8) m_err = 1;
      if (pop) begin
        m_data  = mem[rd & 7];
        m_valid = 1;
        rd      = (rd + 1) & 15;
      end else if (m_valid && rdy_i) begin
        m_valid = 0;
      end
      m_level = 4'((w - rd) & 15);
      m_ae    = (m_level <= 1);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    w = 0;
    step(1'b1, 1'b0);
  endtask

  task automatic push();
    mem[w & 7] = 8'($urandom);
    w = (w + 1) & 15;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    bus.R_READY  = 1'b0;
    bus.rq2_wptr = '0;
    @(negedge clk);
    do_reset();
    do_reset();

    // Idle after reset
    repeat (10) step(1'b0, 1'b0);

    // Three words stepped in with the consumer always ready
    w = 1; step(1'b0, 1'b1);
    w = 2; step(1'b0, 1'b1);
    w = 3; step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("ptr_end", 32'(bus.R_ptr), 32'h2);

    // Backpressure then a single-cycle consume with replacement
    do_reset();
    w = 2;
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("bp_data", 32'(bus.R_DATA), 32'hA1);
    repeat (2) step(1'b0, 1'b0);

    // Wrap-around: twelve words through an eight-entry memory
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (((w - rd) & 15) < 8 && i < 12) push();
      step(1'b0, 1'b1);
    end

    // Full memory behind a held output word, then an inconsistent pointer
    do_reset();
    w = 1;
    repeat (2) step(1'b0, 1'b0);
    w = 9;
    repeat (2) step(1'b0, 1'b0);
    chk("full_lvl", 32'(bus.R_LEVEL), 32'd8);
    w = 10;
    repeat (3) step(1'b0, 1'b0);
    w = 4;
    repeat (2) step(1'b0, 1'b1);
    do_reset();
    repeat (2) step(1'b0, 1'b0);

    // Corrupt pointer straight from reset, then reset while a word is held
    w = 9;
    repeat (3) step(1'b0, 1'b0);
    do_reset();
    repeat (2) step(1'b0, 1'b0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        if (((w - rd) & 15) < 8 && $urandom_range(1) == 1) push();
        step(1'b0, $urandom_range(2) != 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the dual-clock FIFO, operating entirely in the read clock domain. It owns the binary and gray-coded read pointers and generates the empty condition by comparing its gray pointer with the write pointer synchronized into the read domain. It drives the memory read address and presents data through a one-entry first-word-fall-through output register with a valid/ready handshake. It also reports read-side occupancy and flags a pointer-consistency error.

## Interface
- ADDR_WIDTH, 3: memory address width; DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8: word width.
- AE_THRESH, 1: ALMOST_EMPTY asserts when R_LEVEL <= AE_THRESH.
- R_CLK  in  1  read clock; one clock, all logic on its rising edge.
- R_RST  in  1  reset, synchronous, active-high.
- rq2_wptr  in  ADDR_WIDTH+1  gray-coded write pointer from the double-flop synchronizer.
- RD_DATA  in  DATA_WIDTH  memory read data; asynchronous read of R_addr.
- R_READY  in  1  consumer accepts R_DATA this cycle.
- R_ptr  out  ADDR_WIDTH+1  registered gray read pointer, sent to the write-domain synchronizer.
- R_addr  out  ADDR_WIDTH  memory read address = rbin[ADDR_WIDTH-1:0].
- R_DATA  out  DATA_WIDTH  output register data.
- R_VALID  out  1  R_DATA holds an unconsumed word.
- EMPTY  out  1  memory empty as seen by the read side (combinational).
- ALMOST_EMPTY  out  1  registered, = (R_LEVEL <= AE_THRESH).
- R_LEVEL  out  ADDR_WIDTH+1  registered count of words in memory, excluding the output register.
- SYNC_ERR  out  1  sticky pointer-consistency error.

## Operation
- Internal binary pointer rbin (ADDR_WIDTH+1 bits). Invariant: R_ptr == rbin ^ (rbin >> 1) at all times, because R_ptr is loaded with the gray code of rbin's next value on the same edge.
- EMPTY = (R_ptr == rq2_wptr).
- pop = !EMPTY && (!R_VALID || R_READY).
- On pop:
  - R_DATA <= RD_DATA
  - R_VALID <= 1
  - rbin <= rbin + 1 (modulo 2^(ADDR_WIDTH+1); the MSB toggles on address wrap)
- Else, if R_VALID && R_READY: R_VALID <= 0; R_DATA holds its value.
- Else: all state holds. R_READY with R_VALID=0 is a legal no-op.
- Occupancy:
  - wbin_s = gray-to-binary(rq2_wptr).
  - diff = wbin_s - rbin, taken mod 2^(ADDR_WIDTH+1).
  - R_LEVEL <= diff computed with the rbin value after the current edge, so it reflects the post-pop state.
- SYNC_ERR is set, and held until reset, when diff > DEPTH.
- No states beyond the pointer, output register and SYNC_ERR. The handshake behaves as a two-state machine:
  - EMPTY_OUT (R_VALID=0) -> FULL_OUT on pop.
  - FULL_OUT -> FULL_OUT on consume with pop.
  - FULL_OUT -> EMPTY_OUT on consume without pop.

## Timing
- Reset values: rbin=0, R_ptr=0, R_addr=0, R_DATA=0, R_VALID=0, R_LEVEL=0, ALMOST_EMPTY=1, SYNC_ERR=0. EMPTY=1 while rq2_wptr=0.
- Latency:
  - rq2_wptr change making EMPTY=0 -> R_VALID=1 at the next R_CLK edge.
  - R_ptr advances on the same edge.
- Throughput: one word per cycle with R_READY held high and EMPTY=0.
- Simultaneous consume and pop: R_VALID stays 1 and R_DATA is replaced, with no bubble.
- Full memory (diff=DEPTH, R_LEVEL=DEPTH) is legal. EMPTY is 0 because the gray values differ in the two MSBs.
- R_DATA and R_VALID are stable while R_VALID=1 and R_READY=0.
- Reset mid-transfer: all registers return to their reset values on the next edge, and the word in the output register is discarded. The write side must reset in the same window; until it does, diff may be nonzero but SYNC_ERR updates normally.
- R_LEVEL, ALMOST_EMPTY and SYNC_ERR are one cycle behind a rq2_wptr change.

## Test plan
- Reset then idle, rq2_wptr=0:
  - EMPTY=1, R_VALID=0, R_ptr=0, R_LEVEL=0, ALMOST_EMPTY=1 for 10 cycles.
- Step rq2_wptr through gray 0001, 0011, 0010 (3 words) with R_READY=1, memory preloaded A0, A1, A2:
  - R_DATA = A0, A1, A2 on consecutive valid cycles.
  - R_ptr ends at 0010; EMPTY=1 afterwards.
- Backpressure with rq2_wptr=0011 (2 words) and R_READY=0:
  - R_VALID=1 and R_DATA=A0 held; one pop only; R_LEVEL=1.
  - Raise R_READY for 1 cycle -> R_DATA=A1 with no bubble, R_LEVEL=0.
- Wrap-around with ADDR_WIDTH=3:
  - Drain 8 words, then 4 more; R_addr wraps 7 -> 0.
  - R_ptr goes 0100 (bin 7) -> 1100 (bin 8).
- Full case: rbin=0, rq2_wptr=1100 (bin 8):
  - EMPTY=0, R_LEVEL=8, SYNC_ERR=0.
- Corrupt pointer: rbin=0, rq2_wptr=1101 (bin 9):
  - SYNC_ERR=1 next cycle and held until R_RST.
  - R_RST mid-stream clears R_VALID and rbin.
